// File: rtl/regbus_pkg.sv
// Shared types for the register-bus transfer sequencer.
package regbus_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    MOV   = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    SWAP  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    X1   = 2'd1,
    X2   = 2'd2,
    X3   = 2'd3
  } state_e;

endpackage

// File: rtl/regbus_xfer_if.sv
// Command, external-data and bus-observation signals of regbus_xfer.
interface regbus_xfer_if #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int IW    = $clog2(NREGS)
);
  import regbus_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [OP_W-1:0]     cmd_op;
  logic [IW-1:0]       cmd_src;
  logic [IW-1:0]       cmd_dst;
  logic [WIDTH-1:0]    ext_din;
  logic [WIDTH-1:0]    ext_dout;
  logic                ext_dout_valid;
  logic [WIDTH-1:0]    bus;
  logic [NREGS-1:0]    bus_oe;
  logic [NREGS-1:0]    bus_ie;
  logic                err;
  logic                err_clr;

  // Control unit / datapath side
  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, ext_din, err_clr,
    input  cmd_ready, ext_dout, ext_dout_valid, bus, bus_oe, bus_ie, err
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, ext_din, err_clr,
    output cmd_ready, ext_dout, ext_dout_valid, bus, bus_oe, bus_ie, err
  );

endinterface

// File: rtl/regbus_regfile.sv
// NREGS x WIDTH register file: one one-hot write port fed from the bus,
// one asynchronous read port selected by index.
module regbus_regfile #(
  parameter int               WIDTH   = 4,
  parameter int               NREGS   = 4,
  parameter int               IW      = $clog2(NREGS),
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREGS-1:0] we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  // Next register contents: the enabled register takes the bus value
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we[i]) regs_d[i] = wdata;
    end
  end

  // Register array with asynchronous reset to RST_VAL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Asynchronous read; out-of-range indices read as zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_idx == IW'(i)) rd_data = regs_q[i];
    end
  end

endmodule

// File: rtl/regbus_xfer.sv
// Register-bus transfer sequencer: accepts MOV/LOAD/STORE/SWAP commands and
// steps them over a shared internal bus, exporting the per-cycle bus selects.
module regbus_xfer
  import regbus_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter int               NREGS   = 4,
  parameter int               IW      = $clog2(NREGS),
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  regbus_xfer_if.slave bi
);

  localparam logic [IW:0] NR = (IW+1)'(NREGS);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [IW-1:0]    src_q, src_d, dst_q, dst_d;
  logic [WIDTH-1:0] din_q, din_d, tmp_q, tmp_d, dout_q, dout_d;
  logic             dvld_q, dvld_d, err_q, err_d, rdy_q, rdy_d;

  logic             cmd_ready_w, accept, illegal;
  logic [WIDTH-1:0] bus_w, rd_data;
  logic [NREGS-1:0] oe_w, ie_w;
  logic [IW-1:0]    rd_idx;

  function automatic logic in_range(input logic [IW-1:0] idx);
    return {1'b0, idx} < NR;
  endfunction

  function automatic logic [NREGS-1:0] sel(input logic [IW-1:0] idx);
    logic [NREGS-1:0] oh;
    for (int i = 0; i < NREGS; i++) oh[i] = (idx == IW'(i));
    return oh;
  endfunction

  // Ready is held off until the first edge after reset release
  assign cmd_ready_w = rdy_q && (state_q == IDLE);
  assign accept      = bi.cmd_valid && cmd_ready_w;

  // Command decode, FSM next state, command latch and sticky error
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    din_d   = din_q;
    err_d   = err_q;
    rdy_d   = 1'b1;
    illegal = 1'b0;
    unique case (op_e'(bi.cmd_op))
      MOV, SWAP: illegal = !in_range(bi.cmd_src) || !in_range(bi.cmd_dst) ||
                           (bi.cmd_src == bi.cmd_dst);
      LOAD:      illegal = !in_range(bi.cmd_dst);
      STORE:     illegal = !in_range(bi.cmd_src);
      default:   illegal = 1'b1;
    endcase
    // A new error wins over a simultaneous clear
    if (bi.err_clr)          err_d = 1'b0;
    if (accept && illegal)   err_d = 1'b1;
    unique case (state_q)
      IDLE: if (accept && !illegal) begin
        state_d = X1;
        op_d    = op_e'(bi.cmd_op);
        src_d   = bi.cmd_src;
        dst_d   = bi.cmd_dst;
        din_d   = bi.ext_din;
      end
      X1:      state_d = (op_q == SWAP) ? X2 : IDLE;
      X2:      state_d = X3;
      X3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus mux and per-cycle output/input enables
  always_comb begin
    bus_w  = '0;
    oe_w   = '0;
    ie_w   = '0;
    rd_idx = src_q;
    tmp_d  = tmp_q;
    dout_d = dout_q;
    dvld_d = 1'b0;
    unique case (state_q)
      X1: begin
        unique case (op_q)
          MOV: begin
            bus_w = rd_data;
            oe_w  = sel(src_q);
            ie_w  = sel(dst_q);
          end
          LOAD: begin
            bus_w = din_q;
            ie_w  = sel(dst_q);
          end
          STORE: begin
            bus_w  = rd_data;
            oe_w   = sel(src_q);
            dout_d = rd_data;
            dvld_d = 1'b1;
          end
          SWAP: begin
            bus_w = rd_data;
            oe_w  = sel(src_q);
            tmp_d = rd_data;
          end
          default: ;
        endcase
      end
      X2: begin
        rd_idx = dst_q;
        bus_w  = rd_data;
        oe_w   = sel(dst_q);
        ie_w   = sel(src_q);
      end
      X3: begin
        bus_w = tmp_q;
        ie_w  = sel(dst_q);
      end
      default: ;
    endcase
  end

  // State and datapath registers, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= MOV;
      src_q   <= '0;
      dst_q   <= '0;
      din_q   <= '0;
      tmp_q   <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      din_q   <= din_d;
      tmp_q   <= tmp_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  regbus_regfile #(
    .WIDTH  (WIDTH),
    .NREGS  (NREGS),
    .IW     (IW),
    .RST_VAL(RST_VAL)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (ie_w),
    .wdata  (bus_w),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

  assign bi.cmd_ready      = cmd_ready_w;
  assign bi.ext_dout       = dout_q;
  assign bi.ext_dout_valid = dvld_q;
  assign bi.bus            = bus_w;
  assign bi.bus_oe         = oe_w;
  assign bi.bus_ie         = ie_w;
  assign bi.err            = err_q;

endmodule

// File: tb/tb_regbus_xfer.sv
// Bench for regbus_xfer: directed scenarios on a 4x4 instance, random command
// stream on an 8x8 instance checked against a register-array model.
module tb_regbus_xfer;

  localparam int C_MOV = 0, C_LOAD = 1, C_STORE = 2, C_SWAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regbus_xfer_if #(.WIDTH(4), .NREGS(4), .IW(3)) ifa ();
  regbus_xfer_if #(.WIDTH(8), .NREGS(8), .IW(3)) ifb ();

  regbus_xfer #(.WIDTH(4), .NREGS(4), .IW(3), .RST_VAL(4'h0)) u_a (
    .clk(clk), .rst(rst), .bi(ifa));
  regbus_xfer #(.WIDTH(8), .NREGS(8), .IW(3), .RST_VAL(8'h5A)) u_b (
    .clk(clk), .rst(rst), .bi(ifb));

  int total = 0;
  int bad   = 0;
  int pulses_a = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: bus enable invariants every cycle, scoreboard pop on each STORE pulse
  always @(negedge clk) begin
    chk("oe_onehot_a", 32'($countones(ifa.bus_oe) <= 1), 1);
    chk("ie_onehot_a", 32'($countones(ifa.bus_ie) <= 1), 1);
    chk("oe_onehot_b", 32'($countones(ifb.bus_oe) <= 1), 1);
    chk("ie_onehot_b", 32'($countones(ifb.bus_ie) <= 1), 1);
    if (ifa.ext_dout_valid) begin
      pulses_a++;
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL store_a_unexpected: got %0h want no pulse", ifa.ext_dout);
      end else begin
        chk("store_a", 32'(ifa.ext_dout), 32'(qa.pop_front()));
      end
    end
    if (ifb.ext_dout_valid) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL store_b_unexpected: got %0h want no pulse", ifb.ext_dout);
      end else begin
        chk("store_b", 32'(ifb.ext_dout), 32'(qb.pop_front()));
      end
    end
  end

  // Issue one command (called at a falling edge); reports how many cycles
  // cmd_ready stayed low afterwards and the enables seen in the first cycle.
  task automatic send(input bit b, input int op, input int s, input int d,
                      input logic [7:0] din, input bit clr, input bit push,
                      input logic [7:0] exp, output int low,
                      output logic [7:0] oe, output logic [7:0] ie);
    int n = 0;
    while (!(b ? ifb.cmd_ready : ifa.cmd_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL ready_timeout: got ready=0 want ready=1 within 20 cycles");
    end
    if (push) begin
      if (b) qb.push_back(exp);
      else   qa.push_back(exp);
    end
    if (b) begin
      ifb.cmd_op = 2'(op); ifb.cmd_src = 3'(s); ifb.cmd_dst = 3'(d);
      ifb.ext_din = din; ifb.err_clr = clr; ifb.cmd_valid = 1'b1;
    end else begin
      ifa.cmd_op = 2'(op); ifa.cmd_src = 3'(s); ifa.cmd_dst = 3'(d);
      ifa.ext_din = din[3:0]; ifa.err_clr = clr; ifa.cmd_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    ifa.cmd_valid = 1'b0; ifb.cmd_valid = 1'b0;
    ifa.err_clr = 1'b0;   ifb.err_clr = 1'b0;
    ifa.cmd_src = 3'd7;   ifb.cmd_src = 3'd7;
    @(negedge clk);
    oe = b ? ifb.bus_oe : 8'(ifa.bus_oe);
    ie = b ? ifb.bus_ie : 8'(ifa.bus_ie);
    low = 0;
    while (!(b ? ifb.cmd_ready : ifa.cmd_ready) && low < 10) begin
      low++;
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int low;
    logic [7:0] oe, ie;
    logic [7:0] m [8];
    bit merr;
    int op, s, d, explow;
    logic [7:0] din, tv;
    bit clr, ill;
    logic [3:0] exp_a [4];

    ifa.cmd_valid = 0; ifa.cmd_op = 0; ifa.cmd_src = 0; ifa.cmd_dst = 0;
    ifa.ext_din = 0; ifa.err_clr = 0;
    ifb.cmd_valid = 0; ifb.cmd_op = 0; ifb.cmd_src = 0; ifb.cmd_dst = 0;
    ifb.ext_din = 0; ifb.err_clr = 0;

    // Reset state
    #12;
    chk("rst_ready", 32'(ifa.cmd_ready), 0);
    chk("rst_bus", 32'(ifa.bus), 0);
    chk("rst_oe", 32'(ifa.bus_oe), 0);
    chk("rst_ie", 32'(ifa.bus_ie), 0);
    chk("rst_dout", 32'(ifa.ext_dout), 0);
    chk("rst_dvld", 32'(ifa.ext_dout_valid), 0);
    chk("rst_err", 32'(ifa.err), 0);
    chk("rst_ready_b", 32'(ifb.cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(ifa.cmd_ready), 1);

    // STORE every register straight out of reset
    for (int i = 0; i < 4; i++) begin
      send(0, C_STORE, i, 0, 8'h0, 0, 1, 8'h0, low, oe, ie);
      chk("store_spacing", 32'(low), 1);
    end
    @(negedge clk);
    chk("store_pulses", 32'(pulses_a), 4);

    // LOAD, MOV, STORE
    send(0, C_LOAD, 0, 2, 8'hA, 0, 0, 8'h0, low, oe, ie);
    chk("load_spacing", 32'(low), 1);
    chk("load_oe", 32'(oe), 0);
    chk("load_ie", 32'(ie), 32'h4);
    send(0, C_MOV, 2, 0, 8'h0, 0, 0, 8'h0, low, oe, ie);
    chk("mov_oe", 32'(oe), 32'h4);
    chk("mov_ie", 32'(ie), 32'h1);
    send(0, C_STORE, 0, 0, 8'h0, 0, 1, 8'hA, low, oe, ie);
    chk("store_oe", 32'(oe), 32'h1);
    chk("store_ie", 32'(ie), 0);

    // SWAP
    send(0, C_LOAD, 0, 1, 8'h3, 0, 0, 8'h0, low, oe, ie);
    send(0, C_LOAD, 0, 3, 8'hC, 0, 0, 8'h0, low, oe, ie);
    send(0, C_SWAP, 1, 3, 8'h0, 0, 0, 8'h0, low, oe, ie);
    chk("swap_ready_low", 32'(low), 3);
    chk("swap_x1_oe", 32'(oe), 32'h2);
    send(0, C_STORE, 1, 0, 8'h0, 0, 1, 8'hC, low, oe, ie);
    send(0, C_STORE, 3, 0, 8'h0, 0, 1, 8'h3, low, oe, ie);

    // Illegal commands and err handling
    send(0, C_MOV, 2, 2, 8'h0, 0, 0, 8'h0, low, oe, ie);
    chk("mov_same_ready_low", 32'(low), 0);
    chk("mov_same_err", 32'(ifa.err), 1);
    send(0, C_STORE, 5, 0, 8'h0, 0, 0, 8'h0, low, oe, ie);
    chk("store_oor_ready_low", 32'(low), 0);
    chk("store_oor_err", 32'(ifa.err), 1);
    ifa.err_clr = 1'b1;
    @(posedge clk);
    #1 ifa.err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(ifa.err), 0);
    send(0, C_LOAD, 0, 6, 8'hF, 1, 0, 8'h0, low, oe, ie);
    chk("err_set_over_clr", 32'(ifa.err), 1);
    exp_a[0] = 4'hA; exp_a[1] = 4'hC; exp_a[2] = 4'hA; exp_a[3] = 4'h3;
    for (int i = 0; i < 4; i++)
      send(0, C_STORE, i, 0, 8'h0, 0, 1, 8'(exp_a[i]), low, oe, ie);

    // Reset in the middle of a SWAP
    ifa.cmd_op = 2'(C_SWAP); ifa.cmd_src = 3'd0; ifa.cmd_dst = 3'd1;
    ifa.cmd_valid = 1'b1;
    @(posedge clk);
    #1 ifa.cmd_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    chk("swap_x2_oe", 32'(ifa.bus_oe), 32'h2);
    chk("swap_x2_ie", 32'(ifa.bus_ie), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_oe", 32'(ifa.bus_oe), 0);
    chk("midrst_ie", 32'(ifa.bus_ie), 0);
    chk("midrst_bus", 32'(ifa.bus), 0);
    chk("midrst_ready", 32'(ifa.cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_midrst", 32'(ifa.cmd_ready), 1);
    for (int i = 0; i < 4; i++)
      send(0, C_STORE, i, 0, 8'h0, 0, 1, 8'h0, low, oe, ie);
    @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 0);

    // Random command stream against a register-array model
    for (int i = 0; i < 8; i++) m[i] = 8'h5A;
    merr = 1'b0;
    for (int k = 0; k < 300; k++) begin
      op  = int'($urandom_range(0, 3));
      s   = int'($urandom_range(0, 7));
      d   = ($urandom_range(0, 7) == 0) ? s : int'($urandom_range(0, 7));
      din = 8'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      ill = ((op == C_MOV) || (op == C_SWAP)) && (s == d);
      explow = ill ? 0 : ((op == C_SWAP) ? 3 : 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(1, op, s, d, din, clr, (op == C_STORE), m[s], low, oe, ie);
      chk("rand_ready_low", 32'(low), 32'(explow));
      if (ill) merr = 1'b1;
      else begin
        if (clr) merr = 1'b0;
        case (op)
          C_MOV:  m[d] = m[s];
          C_LOAD: m[d] = din;
          C_SWAP: begin tv = m[s]; m[s] = m[d]; m[d] = tv; end
          default: ;
        endcase
      end
      chk("rand_err", 32'(ifb.err), 32'(merr));
    end
    for (int i = 0; i < 8; i++)
      send(1, C_STORE, i, 0, 8'h0, 0, 1, m[i], low, oe, ie);
    @(negedge clk);
    chk("qb_drained", 32'(qb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
